// File: rtl/apuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apuf_pkg
// Description : Shared constants, FSM state encoding and the majority-threshold
//               helper for the arbiter-PUF evaluation controller.
// Revision    : 1.0 - initial release
// ============================================================================
package apuf_pkg;

    localparam int CHAL_W_DEFAULT = 121;

    // Feedback polynomial x^121 + x^18 + 1
    localparam int LFSR_TAP_A = 121;
    localparam int LFSR_TAP_B = 18;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        RISE   = 3'd2,
        SAMPLE = 3'd3,
        FALL   = 3'd4,
        DONE   = 3'd5
    } apuf_state_e;

    function automatic int maj_thresh(input int num_eval);
        return num_eval / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apuf_chal_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : apuf_chal_lfsr
// Description : Fibonacci challenge LFSR with seed load, all-zero seed guard
//               and a single-step advance enable.
// Revision    : 1.0 - initial release
// ============================================================================
module apuf_chal_lfsr
    import apuf_pkg::*;
#(
    parameter int                CHAL_W    = CHAL_W_DEFAULT,
    parameter logic [CHAL_W-1:0] LFSR_INIT = {{(CHAL_W-1){1'b0}}, 1'b1}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [CHAL_W-1:0] i_seed,
    input  logic              i_advance,
    output logic [CHAL_W-1:0] o_chal
);

    logic [CHAL_W-1:0] r_chal;
    logic              w_feedback;

    assign w_feedback = r_chal[LFSR_TAP_A-1] ^ r_chal[LFSR_TAP_B-1];

    // An all-zero state would lock the register, so a zero seed maps to LFSR_INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chal <= LFSR_INIT;
        end else if (i_load) begin
            r_chal <= (i_seed == '0) ? LFSR_INIT : i_seed;
        end else if (i_advance) begin
            r_chal <= {r_chal[CHAL_W-2:0], w_feedback};
        end
    end

    assign o_chal = r_chal;

endmodule
`default_nettype wire

// File: rtl/apuf_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apuf_eval_ctrl
// Description : Drives challenges and race launches into one arbiter PUF,
//               majority-votes NUM_EVAL synchronised samples and returns the
//               result on a valid/ready port. Optional macro
//               APUF_RELIABILITY_EN adds resp_ones / resp_stable outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module apuf_eval_ctrl
    import apuf_pkg::*;
#(
    parameter int                CHAL_W     = CHAL_W_DEFAULT,
    parameter int                SETTLE_CYC = 8,
    parameter int                NUM_EVAL   = 5,
    parameter logic [CHAL_W-1:0] LFSR_INIT  = {{(CHAL_W-1){1'b0}}, 1'b1}
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             seed_load,
    input  logic [CHAL_W-1:0]                seed,
    output logic [CHAL_W-1:0]                chal_o,
    output logic                             launch_o,
    input  logic                             apuf_q_i,
    output logic                             busy,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic                             resp_bit,
`ifdef APUF_RELIABILITY_EN
    output logic [$clog2(NUM_EVAL+1)-1:0]    resp_ones,
    output logic                             resp_stable,
`endif
    output logic [CHAL_W-1:0]                resp_chal
);

    localparam int ONES_W       = $clog2(NUM_EVAL + 1);
    localparam int EVAL_W       = $clog2(NUM_EVAL + 1);
    localparam int CYC_W        = $clog2(SETTLE_CYC);
    localparam int C_MAJ_THRESH = maj_thresh(NUM_EVAL);

    apuf_state_e        r_state;
    logic [CYC_W-1:0]   r_cyc;
    logic [EVAL_W-1:0]  r_eval;
    logic [ONES_W-1:0]  r_ones;
    logic [1:0]         r_sync;
    logic               r_launch;
    logic               r_valid;
    logic               r_resp_bit;
    logic [CHAL_W-1:0]  r_resp_chal;
    logic [ONES_W-1:0]  r_resp_ones;
    logic               r_resp_stable;

    logic               w_settled;
    logic               w_last_race;
    logic               w_lfsr_load;
    logic               w_lfsr_adv;
    logic [CHAL_W-1:0]  w_chal;

    assign w_settled   = (r_cyc == CYC_W'(SETTLE_CYC - 1));
    assign w_last_race = (r_eval == EVAL_W'(NUM_EVAL - 1));
    assign w_lfsr_load = (r_state == IDLE) && seed_load;
    assign w_lfsr_adv  = (r_state == DONE) && resp_ready;

    apuf_chal_lfsr #(
        .CHAL_W    (CHAL_W),
        .LFSR_INIT (LFSR_INIT)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_lfsr_load),
        .i_seed    (seed),
        .i_advance (w_lfsr_adv),
        .o_chal    (w_chal)
    );

    // Free-running synchroniser for the arbiter output, which is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], apuf_q_i};
        end
    end

    // launch_o comes straight from r_launch so the PUF sees a glitch-free edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cyc         <= '0;
            r_eval        <= '0;
            r_ones        <= '0;
            r_launch      <= 1'b0;
            r_valid       <= 1'b0;
            r_resp_bit    <= 1'b0;
            r_resp_chal   <= '0;
            r_resp_ones   <= '0;
            r_resp_stable <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !seed_load) begin
                        r_state <= APPLY;
                        r_cyc   <= '0;
                        r_eval  <= '0;
                        r_ones  <= '0;
                    end
                end
                APPLY: begin
                    r_state  <= RISE;
                    r_launch <= 1'b1;
                    r_cyc    <= '0;
                end
                RISE: begin
                    if (w_settled) begin
                        r_state <= SAMPLE;
                        r_cyc   <= '0;
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end
                SAMPLE: begin
                    r_ones   <= r_ones + ONES_W'(r_sync[1]);
                    r_state  <= FALL;
                    r_launch <= 1'b0;
                end
                FALL: begin
                    if (w_settled) begin
                        r_cyc <= '0;
                        if (w_last_race) begin
                            r_state       <= DONE;
                            r_valid       <= 1'b1;
                            r_resp_bit    <= (r_ones > ONES_W'(C_MAJ_THRESH));
                            r_resp_chal   <= w_chal;
                            r_resp_ones   <= r_ones;
                            r_resp_stable <= (r_ones == '0) || (r_ones == ONES_W'(NUM_EVAL));
                        end else begin
                            r_eval   <= r_eval + EVAL_W'(1);
                            r_state  <= RISE;
                            r_launch <= 1'b1;
                        end
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_launch <= 1'b0;
                    r_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign chal_o     = w_chal;
    assign launch_o   = r_launch;
    assign busy       = (r_state != IDLE);
    assign resp_valid = r_valid;
    assign resp_bit   = r_resp_bit;
    assign resp_chal  = r_resp_chal;

`ifdef APUF_RELIABILITY_EN
    assign resp_ones   = r_resp_ones;
    assign resp_stable = r_resp_stable;
`else
    logic w_unused_rel;
    assign w_unused_rel = ^{r_resp_ones, r_resp_stable};
`endif

endmodule
`default_nettype wire

// File: tb/tb_apuf_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_apuf_eval_ctrl
// Description : Self-checking bench for apuf_eval_ctrl against a cycle-count
//               reference model with directed and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apuf_eval_ctrl;

    localparam int CW   = 121;
    localparam int S    = 8;
    localparam int NE   = 5;
    localparam int RACE = 2 * S + 1;
    localparam int LAT  = 1 + NE * RACE;
    localparam logic [CW-1:0] INIT = {{(CW-1){1'b0}}, 1'b1};

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          start      = 1'b0;
    logic          seed_load  = 1'b0;
    logic [CW-1:0] seed       = '0;
    logic          resp_ready = 1'b0;
    logic          apuf_q_i   = 1'b0;
    logic [CW-1:0] chal_o;
    logic [CW-1:0] resp_chal;
    logic          launch_o;
    logic          busy;
    logic          resp_valid;
    logic          resp_bit;
`ifdef APUF_RELIABILITY_EN
    logic [2:0]    resp_ones;
    logic          resp_stable;
`endif

    always #5 clk = ~clk;

    apuf_eval_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .seed_load   (seed_load),
        .seed        (seed),
        .chal_o      (chal_o),
        .launch_o    (launch_o),
        .apuf_q_i    (apuf_q_i),
        .busy        (busy),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_bit    (resp_bit),
`ifdef APUF_RELIABILITY_EN
        .resp_ones   (resp_ones),
        .resp_stable (resp_stable),
`endif
        .resp_chal   (resp_chal)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] lfsr_next(input logic [CW-1:0] c);
        return {c[CW-2:0], c[120] ^ c[17]};
    endfunction

    // Reference model: 0 = idle, 1 = evaluating (m_t cycles since start), 2 = response held
    int            m_state = 0;
    int            m_t     = 0;
    logic [CW-1:0] m_chal  = INIT;
    bit            race_bits [NE];

    function automatic int exp_ones();
        int n = 0;
        for (int i = 0; i < NE; i++) n += int'(race_bits[i]);
        return n;
    endfunction

    function automatic logic exp_launch();
        if (m_state != 1 || m_t < 1) return 1'b0;
        return ((m_t - 1) % RACE) < (S + 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_t     = 0;
            m_chal  = INIT;
        end else begin
            case (m_state)
                0: begin
                    if (seed_load) m_chal = (seed == '0) ? INIT : seed;
                    else if (start) begin
                        m_state = 1;
                        m_t     = 0;
                    end
                end
                1: begin
                    m_t++;
                    if (m_t == LAT) m_state = 2;
                end
                default: begin
                    m_t++;
                    if (resp_ready) begin
                        m_chal  = lfsr_next(m_chal);
                        m_state = 0;
                    end
                end
            endcase
        end
    end

    // PUF stand-in: holds the chosen bit for the whole of each race
    always @(negedge clk) begin
        if (m_state == 1) begin
            int idx;
            idx = (m_t < 1) ? 0 : (m_t - 1) / RACE;
            if (idx >= NE) idx = NE - 1;
            apuf_q_i = race_bits[idx];
        end else begin
            apuf_q_i = 1'($urandom_range(0, 1));
        end
    end

    logic          prev_launch = 1'b0;
    logic [CW-1:0] prev_chal   = '0;
    int            n_rise      = 0;

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("launch", launch_o, exp_launch());
            check("busy", busy, m_state != 0);
            check("valid", resp_valid, m_state == 2);
            check("chal", chal_o, m_chal);
            if (m_state == 2) begin
                check("resp_bit", resp_bit, exp_ones() > NE / 2);
                check("resp_chal", resp_chal, m_chal);
`ifdef APUF_RELIABILITY_EN
                check("resp_ones", resp_ones, exp_ones());
                check("resp_stable", resp_stable, exp_ones() == 0 || exp_ones() == NE);
`endif
            end
            if (launch_o && prev_launch) check("chal_hold", chal_o, prev_chal);
            if (m_state == 1 && m_t == 0) n_rise = 0;
            if (launch_o && !prev_launch) n_rise++;
            if (m_state == 2 && m_t == LAT) check("n_rise", n_rise, NE);
        end
        prev_launch = launch_o;
        prev_chal   = chal_o;
    end

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!resp_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (!resp_valid) check("valid_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_chal", chal_o, INIT);
        check("rst_launch", launch_o, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_bit", resp_bit, 0);
        check("rst_resp_chal", resp_chal, 0);
        rst_n = 1'b1;

        // All races return 1, consumer always ready
        @(negedge clk);
        for (int i = 0; i < NE; i++) race_bits[i] = 1'b1;
        resp_ready = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(cyc);
        check("latency", cyc, 86);
        check("bit_all1", resp_bit, 1);
        check("chal_all1", resp_chal, INIT);
        @(negedge clk);
        check("chal_adv1", chal_o, 128'h2);
        check("valid_drop", resp_valid, 0);

        // Races 1 and 3 return 1, consumer stalls for 20 cycles
        race_bits[0] = 1'b0; race_bits[1] = 1'b1; race_bits[2] = 1'b0;
        race_bits[3] = 1'b1; race_bits[4] = 1'b0;
        resp_ready = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(cyc);
        repeat (20) @(negedge clk);
        check("bit_2of5", resp_bit, 0);
        check("chal_2of5", resp_chal, 128'h2);
        check("lfsr_stall", chal_o, 128'h2);
`ifdef APUF_RELIABILITY_EN
        check("ones_2of5", resp_ones, 2);
        check("stable_2of5", resp_stable, 0);
`endif
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("chal_adv2", chal_o, 128'h4);

        // Zero seed together with start: seed wins, nothing starts
        seed_load = 1'b1;
        seed      = '0;
        start     = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        start     = 1'b0;
        check("zero_seed", chal_o, INIT);
        repeat (4) @(negedge clk);
        check("zero_seed_busy", busy, 0);

        // Reset in the middle of race 2
        seed_load = 1'b1;
        seed      = {$urandom, $urandom, $urandom, $urandom} | 121'h10;
        @(negedge clk);
        seed_load = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!(m_state == 1 && m_t == 1 + 2 * RACE + 3) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("pre_rst_launch", launch_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_launch", launch_o, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_chal", chal_o, INIT);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic, including requests while busy
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            start      = ($urandom_range(0, 7) == 0);
            seed_load  = ($urandom_range(0, 39) == 0);
            seed       = ($urandom_range(0, 3) == 0) ? '0 : CW'({$urandom, $urandom, $urandom, $urandom});
            resp_ready = ($urandom_range(0, 2) != 0);
            if (m_state == 0)
                for (int i = 0; i < NE; i++) race_bits[i] = 1'($urandom_range(0, 1));
        end
        start     = 1'b0;
        seed_load = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
